// File: rtl/axis_dl_pkg.sv
// rtl/axis_dl_pkg.sv - shared state encoding and block_cycles constants for the deadlock watchdog
package axis_dl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SUSPECT  = 2'd1,
        DEADLOCK = 2'd2
    } dl_state_t;

    localparam int BLOCK_CYCLES_W = 16;
    localparam logic [BLOCK_CYCLES_W-1:0] BLOCK_CYCLES_MAX = 16'hFFFF;

    function automatic logic [BLOCK_CYCLES_W-1:0] sat_inc(input logic [BLOCK_CYCLES_W-1:0] v);
        return (v == BLOCK_CYCLES_MAX) ? v : v + BLOCK_CYCLES_W'(1);
    endfunction

endpackage

// File: rtl/axis_dl_prio_enc.sv
// rtl/axis_dl_prio_enc.sv - lowest-index priority encoder returning index and found
module axis_dl_prio_enc #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    // scan high to low so the lowest set bit is the last one written
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_deadlock_watchdog.sv
// rtl/axis_deadlock_watchdog.sv - region deadlock watchdog; AXIS_DL_STICKY_EN makes DEADLOCK exit only by clear/reset
module axis_deadlock_watchdog
    import axis_dl_pkg::*;
#(
    parameter int                        N_PROC   = 4,
    parameter int                        N_AXIS   = 2,
    parameter logic [N_PROC*N_AXIS-1:0]  AXIS_MAP = '1,
    parameter int                        THRESH   = 16,
    localparam int                       PROC_W   = (N_PROC > 1) ? $clog2(N_PROC) : 1,
    localparam int                       AXIS_W   = (N_AXIS > 1) ? $clog2(N_AXIS) : 1,
    localparam int                       CNT_W    = $clog2(THRESH + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [N_AXIS-1:0]         axis_block_sigs,
    input  logic [N_PROC-1:0]         inst_idle_sigs,
    input  logic [N_PROC-1:0]         inst_block_sigs,
    input  logic [N_PROC-1:0]         child_block,
    output logic                      suspect,
    output logic                      block,
    output logic                      culprit_valid,
    output logic [PROC_W-1:0]         culprit_proc,
    output logic [AXIS_W-1:0]         culprit_axis,
    output logic [BLOCK_CYCLES_W-1:0] block_cycles
);

    localparam logic [CNT_W:0] THRESH_C = (CNT_W + 1)'(THRESH);

    logic [N_AXIS-1:0] owned_blk [N_PROC];
    logic [N_PROC-1:0] axis_blk;
    logic [N_PROC-1:0] stop;
    logic              cond;
    logic              arm;
    logic              thresh_hit;
    logic [PROC_W-1:0] proc_idx;
    logic              proc_found;
    logic [AXIS_W-1:0] axis_idx;
    logic              axis_found;

    dl_state_t         state;
    logic [CNT_W-1:0]  cnt;

    for (genvar p = 0; p < N_PROC; p++) begin : g_proc
        assign owned_blk[p] = axis_block_sigs & AXIS_MAP[p*N_AXIS +: N_AXIS];
        assign axis_blk[p]  = child_block[p] & (|owned_blk[p]);
        assign stop[p]      = inst_idle_sigs[p] | inst_block_sigs[p] | axis_blk[p];
    end

    assign cond = enable & (|axis_blk) & (&stop);

    axis_dl_prio_enc #(
        .WIDTH (N_PROC),
        .IDX_W (PROC_W)
    ) u_proc_enc (
        .req   (axis_blk),
        .index (proc_idx),
        .found (proc_found)
    );

    axis_dl_prio_enc #(
        .WIDTH (N_AXIS),
        .IDX_W (AXIS_W)
    ) u_axis_enc (
        .req   (owned_blk[proc_idx]),
        .index (axis_idx),
        .found (axis_found)
    );

    // cond already implies both encoders found a hit; folding them in keeps the capture self-consistent
    assign arm = cond & proc_found & axis_found;

    // IDLE holds cnt at zero, so one expression covers both the THRESH==1 and counted paths
    assign thresh_hit = (state == IDLE || state == SUSPECT) &&
                        (({1'b0, cnt} + (CNT_W + 1)'(1)) == THRESH_C);

    // detection FSM with registered outputs and culprit capture on DEADLOCK entry
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state         <= IDLE;
            cnt           <= '0;
            suspect       <= 1'b0;
            block         <= 1'b0;
            culprit_valid <= 1'b0;
            culprit_proc  <= '0;
            culprit_axis  <= '0;
            block_cycles  <= '0;
        end else begin
            case (state)
                IDLE, SUSPECT: begin
                    if (!arm) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        suspect <= 1'b0;
                    end else if (thresh_hit) begin
                        state         <= DEADLOCK;
                        cnt           <= '0;
                        suspect       <= 1'b0;
                        block         <= 1'b1;
                        culprit_valid <= 1'b1;
                        culprit_proc  <= proc_idx;
                        culprit_axis  <= axis_idx;
                        block_cycles  <= '0;
                    end else begin
                        state   <= SUSPECT;
                        cnt     <= cnt + CNT_W'(1);
                        suspect <= 1'b1;
                    end
                end
                DEADLOCK: begin
`ifdef AXIS_DL_STICKY_EN
                    block_cycles <= sat_inc(block_cycles);
`else
                    if (!arm) begin
                        state         <= IDLE;
                        block         <= 1'b0;
                        culprit_valid <= 1'b0;
                        culprit_proc  <= '0;
                        culprit_axis  <= '0;
                    end else begin
                        block_cycles <= sat_inc(block_cycles);
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_deadlock_watchdog.sv
// tb/tb_axis_deadlock_watchdog.sv - directed self-checking bench for axis_deadlock_watchdog
module tb_axis_deadlock_watchdog;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear;
    logic [1:0] axis_block_sigs;
    logic [3:0] inst_idle_sigs;
    logic [3:0] inst_block_sigs;
    logic [3:0] child_block;

    logic        a_suspect, a_block, a_cvalid;
    logic [1:0]  a_cproc;
    logic [0:0]  a_caxis;
    logic [15:0] a_bc;

    logic        b_suspect, b_block, b_cvalid;
    logic [1:0]  b_cproc;
    logic [0:0]  b_caxis;
    logic [15:0] b_bc;

    logic        c_suspect, c_block, c_cvalid;
    logic [1:0]  c_cproc;
    logic [0:0]  c_caxis;
    logic [15:0] c_bc;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    axis_deadlock_watchdog #(.N_PROC(4), .N_AXIS(2), .AXIS_MAP(8'hFF), .THRESH(4)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs), .child_block(child_block),
        .suspect(a_suspect), .block(a_block), .culprit_valid(a_cvalid),
        .culprit_proc(a_cproc), .culprit_axis(a_caxis), .block_cycles(a_bc)
    );

    axis_deadlock_watchdog #(.N_PROC(4), .N_AXIS(2), .AXIS_MAP(8'hFF), .THRESH(1)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs), .child_block(child_block),
        .suspect(b_suspect), .block(b_block), .culprit_valid(b_cvalid),
        .culprit_proc(b_cproc), .culprit_axis(b_caxis), .block_cycles(b_bc)
    );

    axis_deadlock_watchdog #(.N_PROC(4), .N_AXIS(2), .AXIS_MAP(8'h69), .THRESH(4)) dut_c (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs), .child_block(child_block),
        .suspect(c_suspect), .block(c_block), .culprit_valid(c_cvalid),
        .culprit_proc(c_cproc), .culprit_axis(c_caxis), .block_cycles(c_bc)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] ax, input logic [3:0] idle,
                         input logic [3:0] iblk, input logic [3:0] child);
        enable          = en;
        axis_block_sigs = ax;
        inst_idle_sigs  = idle;
        inst_block_sigs = iblk;
        child_block     = child;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_a_outs"}, {26'd0, a_suspect, a_block, a_cvalid, a_cproc, a_caxis}, 32'd0);
        chk({tag, "_a_bc"}, {16'd0, a_bc}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        drive(1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        step();
        step();
        chk_zero_a("reset");
        chk("reset_b_outs", {26'd0, b_suspect, b_block, b_cvalid, b_cproc, b_caxis}, 32'd0);
        reset = 1'b0;

        // process 2 AXIS-blocked on channel 1, everyone else idle
        drive(1'b1, 2'b10, 4'b1011, 4'b0000, 4'b0100);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i <= 3) begin
                chk($sformatf("t1_suspect_%0d", i), {31'd0, a_suspect}, 32'd1);
                chk($sformatf("t1_noblock_%0d", i), {31'd0, a_block}, 32'd0);
            end else begin
                chk($sformatf("t1_block_%0d", i), {31'd0, a_block}, 32'd1);
                chk($sformatf("t1_nosusp_%0d", i), {31'd0, a_suspect}, 32'd0);
            end
            if (i == 1) chk("t1_b_block_c1", {31'd0, b_block}, 32'd1);
            if (i == 4) begin
                chk("t1_cvalid", {31'd0, a_cvalid}, 32'd1);
                chk("t1_cproc", {30'd0, a_cproc}, 32'd2);
                chk("t1_caxis", {31'd0, a_caxis}, 32'd1);
                chk("t1_bc_entry", {16'd0, a_bc}, 32'd0);
            end
        end
        chk("t1_bc_10", {16'd0, a_bc}, 32'd6);

        // condition drops
        drive(1'b1, 2'b10, 4'b1011, 4'b0000, 4'b0000);
        step();
`ifdef AXIS_DL_STICKY_EN
        chk("drop_block_sticky", {31'd0, a_block}, 32'd1);
        chk("drop_cproc_sticky", {30'd0, a_cproc}, 32'd2);
        chk("drop_bc_sticky", {16'd0, a_bc}, 32'd7);
        step();
        chk("drop2_block_sticky", {31'd0, a_block}, 32'd1);
`else
        chk("drop_block", {31'd0, a_block}, 32'd0);
        chk("drop_cvalid", {31'd0, a_cvalid}, 32'd0);
        chk("drop_cproc", {30'd0, a_cproc}, 32'd0);
        chk("drop_bc_hold", {16'd0, a_bc}, 32'd6);
`endif
        do_clear();
        chk_zero_a("clear");

        // 3 cycles of cond, 1 gap, then restart
        drive(1'b1, 2'b10, 4'b1011, 4'b0000, 4'b0100);
        step();
        step();
        step();
        chk("rs_suspect", {31'd0, a_suspect}, 32'd1);
        enable = 1'b0;
        step();
        chk("rs_gap_outs", {30'd0, a_suspect, a_block}, 32'd0);
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("rs_block_%0d", i), {31'd0, a_block}, (i == 4) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        do_clear();

        // process 0 busy: never a deadlock
        drive(1'b1, 2'b11, 4'b1110, 4'b0000, 4'b0110);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i % 5 == 0)
                chk($sformatf("busy_outs_%0d", i), {30'd0, a_suspect, a_block}, 32'd0);
        end

        // enable low masks an otherwise full condition
        drive(1'b0, 2'b10, 4'b1011, 4'b0000, 4'b0100);
        step();
        step();
        chk("en_low_outs", {30'd0, a_suspect, a_block}, 32'd0);

        // ownership map changes the culprit channel
        drive(1'b1, 2'b11, 4'b0011, 4'b0000, 4'b1100);
        repeat (4) step();
        chk("map_a_block", {31'd0, a_block}, 32'd1);
        chk("map_a_cul", {29'd0, a_cproc, a_caxis}, {29'd0, 2'd2, 1'b0});
        chk("map_c_block", {31'd0, c_block}, 32'd1);
        chk("map_c_cul", {29'd0, c_cproc, c_caxis}, {29'd0, 2'd2, 1'b1});

        // clear while cond is high, then THRESH=1 saturation
        drive(1'b1, 2'b10, 4'b1011, 4'b0000, 4'b0100);
        do_clear();
        chk("clrcond_a_outs", {30'd0, a_suspect, a_block}, 32'd0);
        chk("clrcond_b_block", {31'd0, b_block}, 32'd0);
        step();
        chk("clrcond_a_susp", {31'd0, a_suspect}, 32'd1);
        chk("clrcond_b_block1", {31'd0, b_block}, 32'd1);
        chk("clrcond_b_bc", {16'd0, b_bc}, 32'd0);
        step();
        step();
        chk("clrcond_a_noblk", {31'd0, a_block}, 32'd0);
        step();
        chk("clrcond_a_blk", {31'd0, a_block}, 32'd1);

        repeat (70000) @(posedge clock);
        #1;
        chk("sat_b_block", {31'd0, b_block}, 32'd1);
        chk("sat_b_bc", {16'd0, b_bc}, 32'h0000FFFF);

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_b_outs", {26'd0, b_suspect, b_block, b_cvalid, b_cproc, b_caxis}, 32'd0);
        chk("rst_b_bc", {16'd0, b_bc}, 32'd0);
        chk_zero_a("rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
